// File: rtl/fabric_cfg_pkg.sv
// rtl/fabric_cfg_pkg.sv - register map, status/ctrl bit positions and FSM states for the eFPGA self-config bridge
package fabric_cfg_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_ID     = 2'd3;

  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_BUSY      = 2;
  localparam int ST_OVERFLOW  = 3;
  localparam int ST_DONE      = 4;
  localparam int ST_COUNT_LSB = 8;
  localparam int ST_SENT_LSB  = 16;

  localparam int CTRL_ENABLE    = 0;
  localparam int CTRL_FLUSH     = 1;
  localparam int CTRL_CLR_OVF   = 2;
  localparam int CTRL_CLR_DONE  = 3;

  localparam logic [31:0] ID_VALUE = 32'hFAB0_C0F1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    GAP    = 2'd2
  } cfg_state_e;

  function automatic logic [31:0] pack_status(
    input logic        empty,
    input logic        full,
    input logic        busy,
    input logic        overflow,
    input logic        done,
    input logic [3:0]  count,
    input logic [15:0] words_sent
  );
    logic [31:0] s;
    s = '0;
    s[ST_EMPTY]    = empty;
    s[ST_FULL]     = full;
    s[ST_BUSY]     = busy;
    s[ST_OVERFLOW] = overflow;
    s[ST_DONE]     = done;
    s[ST_COUNT_LSB +: 4] = count;
    s[ST_SENT_LSB +: 16] = words_sent;
    return s;
  endfunction

endpackage

// File: rtl/cfg_word_fifo.sv
// rtl/cfg_word_fifo.sv - synchronous config-word FIFO with flush
module cfg_word_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/wb_self_config_bridge.sv
// rtl/wb_self_config_bridge.sv - Wishbone slave that queues config words and replays them to the eFPGA self-write port
module wb_self_config_bridge #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter int          GAP_CYCLES = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        SelfWriteStrobe,
  output logic [31:0] SelfWriteData,
  output logic        irq
);
  import fabric_cfg_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic              addr_hit, access, bus_wr, bus_rd;
  logic [1:0]        reg_sel;
  logic              push_req, ctrl_wr, flush, clr_ovf, clr_done;
  logic              enable, overflow, done, emitted;
  logic [15:0]       words_sent;
  logic [31:0]       rdata;
  logic              fifo_pop, fifo_empty, fifo_full, fifo_empty_next;
  logic [31:0]       fifo_dout;
  logic [CNT_W-1:0]  fifo_count;
  cfg_state_e        state, next_state;
  logic [3:0]        gap_cnt, gap_next;
  logic              enter_idle, done_set;
  logic              unused_bits;

  assign unused_bits = &{1'b0, wbs_sel_i, wbs_adr_i[1:0]};

  assign addr_hit = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign access   = wbs_stb_i & wbs_cyc_i & addr_hit & ~wbs_ack_o;
  assign bus_wr   = access & wbs_we_i;
  assign bus_rd   = access & ~wbs_we_i;
  assign reg_sel  = wbs_adr_i[3:2];
  assign push_req = bus_wr && (reg_sel == REG_DATA);
  assign ctrl_wr  = bus_wr && (reg_sel == REG_CTRL);
  assign flush    = ctrl_wr & wbs_dat_i[CTRL_FLUSH];
  assign clr_ovf  = ctrl_wr & wbs_dat_i[CTRL_CLR_OVF];
  assign clr_done = ctrl_wr & wbs_dat_i[CTRL_CLR_DONE];

  cfg_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .push  (push_req),
    .pop   (fifo_pop),
    .flush (flush),
    .din   (wbs_dat_i),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_STATUS: rdata = pack_status(fifo_empty, fifo_full, state != IDLE, overflow, done,
                                      4'(fifo_count), words_sent);
      REG_CTRL:   rdata = {31'b0, enable};
      REG_ID:     rdata = ID_VALUE;
      default:    rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      enable    <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      wbs_ack_o <= access;
      wbs_dat_o <= bus_rd ? rdata : '0;
      if (ctrl_wr) enable <= wbs_dat_i[CTRL_ENABLE];
      // a write to a full FIFO is lost even if the FSM pops on the same edge
      if (push_req && fifo_full) overflow <= 1'b1;
      else if (clr_ovf)          overflow <= 1'b0;
    end
  end

  always_comb begin
    next_state = state;
    gap_next   = gap_cnt;
    fifo_pop   = 1'b0;
    case (state)
      IDLE: begin
        if (enable && !fifo_empty && !flush) begin
          fifo_pop   = 1'b1;
          next_state = STROBE;
        end
      end
      STROBE: begin
        if (GAP_CYCLES == 0) begin
          next_state = IDLE;
        end else begin
          next_state = GAP;
          gap_next   = 4'(GAP_CYCLES);
        end
      end
      GAP: begin
        gap_next = gap_cnt - 4'd1;
        if (gap_cnt <= 4'd1) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // FIFO occupancy as it will be after this edge; the FSM never pops outside IDLE
  assign fifo_empty_next = flush | (fifo_empty & ~push_req);
  assign enter_idle      = (next_state == IDLE) && (state != IDLE);
  assign done_set        = enter_idle & fifo_empty_next & (emitted | (state == STROBE));

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state         <= IDLE;
      gap_cnt       <= '0;
      SelfWriteData <= '0;
      words_sent    <= '0;
      done          <= 1'b0;
      emitted       <= 1'b0;
    end else begin
      state   <= next_state;
      gap_cnt <= gap_next;
      if (fifo_pop)        SelfWriteData <= fifo_dout;
      if (state == STROBE) words_sent    <= words_sent + 16'd1;
      if (done_set)        done          <= 1'b1;
      else if (clr_done)   done          <= 1'b0;
      if (state == STROBE) emitted       <= 1'b1;
      else if (clr_done)   emitted       <= 1'b0;
    end
  end

  assign SelfWriteStrobe = (state == STROBE);
  assign irq             = done;

endmodule

// File: tb/tb_wb_self_config_bridge.sv
// tb/tb_wb_self_config_bridge.sv - scoreboard bench for wb_self_config_bridge
module tb_wb_self_config_bridge;

  localparam logic [31:0] B   = 32'h3000_0000;
  localparam logic [31:0] B0  = 32'h3000_0010;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb, cyc_i, we;
  logic [3:0]  sel;
  logic [31:0] adr_i, dat_i;
  logic        ack, ack0;
  logic [31:0] dat, dat0;
  logic        strb, strb0;
  logic [31:0] sdat, sdat0;
  logic        irq, irq0;

  int tick = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    int          at;
  } strb_t;

  strb_t       exp_s[$];
  strb_t       exp_s0[$];
  logic [31:0] exp_rd[$];

  always #5 clk = ~clk;
  always @(posedge clk) tick <= tick + 1;

  wb_self_config_bridge dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc_i), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr_i), .wbs_dat_i(dat_i), .wbs_ack_o(ack), .wbs_dat_o(dat),
    .SelfWriteStrobe(strb), .SelfWriteData(sdat), .irq(irq)
  );

  wb_self_config_bridge #(.BASE_ADDR(B0), .FIFO_DEPTH(4), .GAP_CYCLES(0)) dut0 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc_i), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr_i), .wbs_dat_i(dat_i), .wbs_ack_o(ack0), .wbs_dat_o(dat0),
    .SelfWriteStrobe(strb0), .SelfWriteData(sdat0), .irq(irq0)
  );

  always @(negedge clk) begin
    logic [31:0] e, got;
    strb_t s;
    if (!rst) begin
      if ((ack || ack0) && !we) begin
        checks++;
        got = ack ? dat : dat0;
        if (exp_rd.size() == 0) begin
          errors++;
          $display("FAIL rd_unexpected got %h", got);
        end else begin
          e = exp_rd.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL rd_data got %h exp %h", got, e);
          end
        end
      end
      if (strb) begin
        checks++;
        if (exp_s.size() == 0) begin
          errors++;
          $display("FAIL strobe_unexpected data %h at %0d", sdat, tick);
        end else begin
          s = exp_s.pop_front();
          if (sdat !== s.data || tick != s.at) begin
            errors++;
            $display("FAIL strobe got %h@%0d exp %h@%0d", sdat, tick, s.data, s.at);
          end
        end
      end
      if (strb0) begin
        checks++;
        if (exp_s0.size() == 0) begin
          errors++;
          $display("FAIL strobe0_unexpected data %h at %0d", sdat0, tick);
        end else begin
          s = exp_s0.pop_front();
          if (sdat0 !== s.data || tick != s.at) begin
            errors++;
            $display("FAIL strobe0 got %h@%0d exp %h@%0d", sdat0, tick, s.data, s.at);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                      input logic exp_ack, output int ack_cyc);
    logic got;
    @(posedge clk); #1;
    stb = 1'b1; cyc_i = 1'b1; we = w; adr_i = a; dat_i = d;
    got = 1'b0;
    ack_cyc = -1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ack || ack0) begin
        got = 1'b1;
        ack_cyc = tick;
        break;
      end
    end
    stb = 1'b0; cyc_i = 1'b0;
    checks++;
    if (got !== exp_ack) begin
      errors++;
      $display("FAIL ack adr %h got %0d exp %0d", a, got, exp_ack);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, output int c);
    xfer(a, 1'b1, d, 1'b1, c);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e);
    int c;
    exp_rd.push_back(e);
    xfer(a, 1'b0, 32'h0, 1'b1, c);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, e;
    rst = 1'b1; stb = 1'b0; cyc_i = 1'b0; we = 1'b0; sel = 4'hF; adr_i = '0; dat_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {31'b0, ack}, 32'h0);
    check("rst_dat", dat, 32'h0);
    check("rst_strobe", {31'b0, strb}, 32'h0);
    check("rst_sdata", sdat, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    rst = 1'b0;

    rd(B + 32'hC, 32'hFAB0_C0F1);
    rd(B + 32'h4, 32'h0000_0001);
    rd(B + 32'h0, 32'h0);
    rd(B + 32'h8, 32'h0);
    rd(B0 + 32'hC, 32'hFAB0_C0F1);
    xfer(32'h3000_0020, 1'b0, 32'h0, 1'b0, n);

    // single word: strobe one cycle after ack, then done
    wr(B + 32'h8, 32'h1, n);
    wr(B + 32'h0, 32'hDEAD_BEEF, n);
    exp_s.push_back('{32'hDEAD_BEEF, n + 1});
    repeat (8) @(posedge clk);
    #1;
    check("irq_done", {31'b0, irq}, 32'h1);
    rd(B + 32'h4, 32'h0001_0011);
    wr(B + 32'h8, 32'h9, n);
    check("irq_clr", {31'b0, irq}, 32'h0);
    rd(B + 32'h4, 32'h0001_0001);

    // overflow with enable off, then drain 4 words 4 cycles apart
    wr(B + 32'h8, 32'h0, n);
    for (int i = 0; i < 5; i++) wr(B + 32'h0, 32'hA000_0000 + i, n);
    rd(B + 32'h4, 32'h0001_040A);
    wr(B + 32'h8, 32'h1, e);
    for (int i = 0; i < 4; i++) exp_s.push_back('{32'hA000_0000 + i, e + 1 + 4 * i});
    repeat (20) @(posedge clk);
    rd(B + 32'h4, 32'h0005_0019);
    wr(B + 32'h8, 32'hC, n);
    rd(B + 32'h4, 32'h0005_0001);

    // flush during the first gap
    for (int i = 0; i < 3; i++) wr(B + 32'h0, 32'hB000_0000 + i, n);
    wr(B + 32'h8, 32'h1, e);
    exp_s.push_back('{32'hB000_0000, e + 1});
    wr(B + 32'h8, 32'h3, n);
    check("flush_in_gap", n, e + 2);
    repeat (12) @(posedge clk);
    rd(B + 32'h4, 32'h0006_0011);
    wr(B + 32'h8, 32'h9, n);

    // GAP_CYCLES=0 instance: strobes every 2 cycles
    for (int i = 0; i < 3; i++) wr(B0 + 32'h0, 32'hC000_0000 + i, n);
    wr(B0 + 32'h8, 32'h1, e);
    for (int i = 0; i < 3; i++) exp_s0.push_back('{32'hC000_0000 + i, e + 1 + 2 * i});
    repeat (8) @(posedge clk);
    rd(B0 + 32'h4, 32'h0003_0011);

    // reset during STROBE
    wr(B + 32'h0, 32'hD000_0000, n);
    exp_s.push_back('{32'hD000_0000, n + 1});
    @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst_async_strobe", {31'b0, strb}, 32'h0);
    check("rst_async_sdata", sdat, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    rd(B + 32'h4, 32'h0000_0001);
    check("rst_irq_after", {31'b0, irq}, 32'h0);
    repeat (10) @(posedge clk);
    wr(B + 32'h8, 32'h1, n);
    wr(B + 32'h0, 32'hE000_0000, n);
    exp_s.push_back('{32'hE000_0000, n + 1});
    repeat (8) @(posedge clk);
    #1;

    check("exp_s_drained", exp_s.size(), 32'h0);
    check("exp_s0_drained", exp_s0.size(), 32'h0);
    check("exp_rd_drained", exp_rd.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
